// File: rtl/mem_responder_if.sv
// Request/response handshake between the LC-3 control FSM (master) and the
// memory responder (slave). The request fields are held by the master until R.
interface mem_responder_if;
  logic        MEM_EN;
  logic        WE;
  logic [15:0] MAR;
  logic [15:0] MDR;
  logic [15:0] MDR_In;
  logic        R;

  modport master (output MEM_EN, WE, MAR, MDR, input MDR_In, R);
  modport slave  (input MEM_EN, WE, MAR, MDR, output MDR_In, R);
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder for the LC-3 MAR/MDR interface. It drives an async
// SRAM with WAIT_CYCLES (1..15) strobe cycles per access, returns read data on
// MDR_In and gives a single-cycle R pulse. Address IO_ADDR is a memory-mapped
// port: reads return the switches S, and writes load HEX_DATA.
//
// Optional build macro MEM_WRITE_PROTECT_EN: non-I/O writes below 16'h3000 are
// refused without touching the SRAM, still acknowledged, and they set the
// sticky PROT_ERR output.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for MEM_EN; the request is latched on acceptance
// ACCESS  | SRAM strobes active, wait counter running down to zero
// RESP    | R high for this one cycle, strobes released
// RELEASE | waiting for MEM_EN to drop so a held request is not re-run
module mem_responder #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic           Clk,
  input  logic           Reset,
  mem_responder_if.slave bus,
  input  logic [15:0]    S,
  output logic [15:0]    HEX_DATA,
  output logic [19:0]    SRAM_ADDR,
  output logic [15:0]    SRAM_D_OUT,
  input  logic [15:0]    SRAM_D_IN,
  output logic           SRAM_DQ_OE,
  output logic           SRAM_CE_N,
  output logic           SRAM_OE_N,
  output logic           SRAM_WE_N
`ifdef MEM_WRITE_PROTECT_EN
  ,
  output logic           PROT_ERR
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESP    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Counter reload; the last strobe cycle is the one where the count is zero.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

`ifdef MEM_WRITE_PROTECT_EN
  localparam logic [15:0] PROT_LIMIT = 16'h3000;
`endif

  state_t     state;
  logic [3:0] wait_cnt;
  logic       we_q;

  // Single-process FSM. SRAM_ADDR and SRAM_D_OUT double as the latched copies
  // of MAR and MDR, so later changes on the request bus cannot leak in.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      we_q       <= 1'b0;
      bus.R      <= 1'b0;
      bus.MDR_In <= 16'h0000;
      HEX_DATA   <= 16'h0000;
      SRAM_ADDR  <= 20'h00000;
      SRAM_D_OUT <= 16'h0000;
      SRAM_DQ_OE <= 1'b0;
      SRAM_CE_N  <= 1'b1;
      SRAM_OE_N  <= 1'b1;
      SRAM_WE_N  <= 1'b1;
`ifdef MEM_WRITE_PROTECT_EN
      PROT_ERR   <= 1'b0;
`endif
    end else begin
      bus.R <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.MEM_EN) begin
            we_q <= bus.WE;
            if (bus.MAR == IO_ADDR) begin
              // I/O port: completes immediately, SRAM stays untouched.
              state <= RESP;
              bus.R <= 1'b1;
              if (bus.WE) begin
                HEX_DATA <= bus.MDR;
              end else begin
                bus.MDR_In <= S;
              end
            end
`ifdef MEM_WRITE_PROTECT_EN
            else if (bus.WE && (bus.MAR < PROT_LIMIT)) begin
              // Refused write: acknowledged like I/O but flagged.
              state    <= RESP;
              bus.R    <= 1'b1;
              PROT_ERR <= 1'b1;
            end
`endif
            else begin
              state     <= ACCESS;
              wait_cnt  <= WAIT_LOAD;
              SRAM_ADDR <= {4'b0000, bus.MAR};
              SRAM_CE_N <= 1'b0;
              if (bus.WE) begin
                SRAM_WE_N  <= 1'b0;
                SRAM_DQ_OE <= 1'b1;
                SRAM_D_OUT <= bus.MDR;
              end else begin
                SRAM_OE_N <= 1'b0;
              end
            end
          end
        end

        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            state      <= RESP;
            bus.R      <= 1'b1;
            SRAM_CE_N  <= 1'b1;
            SRAM_OE_N  <= 1'b1;
            SRAM_WE_N  <= 1'b1;
            SRAM_DQ_OE <= 1'b0;
            if (!we_q) begin
              bus.MDR_In <= SRAM_D_IN;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        RESP: begin
          state <= RELEASE;
        end

        RELEASE: begin
          if (!bus.MEM_EN) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios followed by random traffic.
// A driver issues requests and pushes the expected outcome into a queue; an
// independent monitor checks strobes, latency, access length and data.
module tb_mem_responder;
  localparam int          WAIT = 2;
  localparam logic [15:0] IO   = 16'hFFFF;
`ifdef MEM_WRITE_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] rdata;
    bit          io;
    bit          prot;
    int          issue;
    int          lat;
    int          acc;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] s_val = 16'h0000;
  logic [15:0] hex_data;
  logic [19:0] sram_addr;
  logic [15:0] sram_d_out;
  logic [15:0] sram_d_in = 16'h0000;
  logic        dq_oe, ce_n, oe_n, we_n;
`ifdef MEM_WRITE_PROTECT_EN
  logic        prot_err;
`endif

  mem_responder_if bus ();

  mem_responder #(.WAIT_CYCLES(WAIT), .IO_ADDR(IO)) dut (
    .Clk        (clk),
    .Reset      (rst),
    .bus        (bus.slave),
    .S          (s_val),
    .HEX_DATA   (hex_data),
    .SRAM_ADDR  (sram_addr),
    .SRAM_D_OUT (sram_d_out),
    .SRAM_D_IN  (sram_d_in),
    .SRAM_DQ_OE (dq_oe),
    .SRAM_CE_N  (ce_n),
    .SRAM_OE_N  (oe_n),
    .SRAM_WE_N  (we_n)
`ifdef MEM_WRITE_PROTECT_EN
    ,
    .PROT_ERR   (prot_err)
`endif
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   rst_seen = 1'b0;
  bit   armed    = 1'b0;
  txn_t exp_q[$];

  logic [15:0] ref_mem  [logic [15:0]];
  logic [15:0] sram_mem [logic [15:0]];

  logic [15:0] exp_mdr  = 16'h0000;
  logic [15:0] exp_hex  = 16'h0000;
  bit          exp_prot = 1'b0;
  int          acc_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Contents of never-written SRAM locations.
  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Reference model: what a request should do, from the behavioural rules.
  function automatic void push_txn(input logic we, input logic [15:0] a, input logic [15:0] d);
    txn_t t;
    t.we    = we;
    t.addr  = a;
    t.data  = d;
    t.io    = (a == IO);
    t.prot  = PROT && we && !t.io && (a < 16'h3000);
    t.issue = cyc;
    t.lat   = (t.io || t.prot) ? 1 : WAIT + 1;
    t.acc   = (t.io || t.prot) ? 0 : WAIT;
    t.rdata = t.io ? s_val : ref_read(a);
    if (we && !t.io && !t.prot) ref_mem[a] = d;
    exp_q.push_back(t);
  endfunction

  // Cycle counter and reset bookkeeping; a reset discards pending work.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
    if (rst) begin
      exp_q.delete();
      armed <= 1'b1;
    end
  end

  // Asynchronous SRAM model, evaluated mid-cycle while strobes are stable.
  always @(negedge clk) begin
    if (!ce_n && !we_n) sram_mem[sram_addr[15:0]] = sram_d_out;
    if (!ce_n && !oe_n)
      sram_d_in <= sram_mem.exists(sram_addr[15:0]) ? sram_mem[sram_addr[15:0]] : init_val(sram_addr[15:0]);
    else
      sram_d_in <= 16'h0000;
  end

  // Monitor: per-cycle checks, and completion checks whenever R is seen.
  always @(negedge clk) begin
    txn_t t;
    if (armed) begin
      if (rst_seen) begin
        check("rst_r", {31'd0, bus.R}, 32'd0);
        check("rst_strobes", {28'd0, ce_n, oe_n, we_n, dq_oe}, 32'hE);
        check("rst_mdr_in", {16'd0, bus.MDR_In}, 32'd0);
        check("rst_hex", {16'd0, hex_data}, 32'd0);
        check("rst_sram_addr", {12'd0, sram_addr}, 32'd0);
        check("rst_d_out", {16'd0, sram_d_out}, 32'd0);
        exp_mdr  = 16'h0000;
        exp_hex  = 16'h0000;
        exp_prot = 1'b0;
        acc_cnt  = 0;
      end else begin
        if (!ce_n) begin
          acc_cnt++;
          check("access_pending", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            t = exp_q[0];
            check("access_kind", {31'd0, t.io || t.prot}, 32'd0);
            check("sram_addr", {12'd0, sram_addr}, {16'd0, t.addr});
            if (t.we) begin
              check("wr_strobes", {29'd0, oe_n, we_n, dq_oe}, 32'h5);
              check("d_out", {16'd0, sram_d_out}, {16'd0, t.data});
            end else begin
              check("rd_strobes", {29'd0, oe_n, we_n, dq_oe}, 32'h2);
            end
          end
        end else begin
          check("idle_strobes", {29'd0, oe_n, we_n, dq_oe}, 32'h6);
        end
        if (bus.R) begin
          check("r_pending", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            t = exp_q.pop_front();
            check("latency", cyc - t.issue, t.lat);
            check("access_cycles", acc_cnt, t.acc);
            if (!t.we) exp_mdr = t.rdata;
            if (t.we && t.io) exp_hex = t.data;
            if (t.prot) exp_prot = 1'b1;
          end
          acc_cnt = 0;
        end
        check("mdr_in", {16'd0, bus.MDR_In}, {16'd0, exp_mdr});
        check("hex_data", {16'd0, hex_data}, {16'd0, exp_hex});
`ifdef MEM_WRITE_PROTECT_EN
        check("prot_err", {31'd0, prot_err}, {31'd0, exp_prot});
`endif
      end
    end
  end

  // Wait (bounded) for R; optionally drop MEM_EN early and/or disturb the
  // request fields after acceptance.
  task automatic wait_r(input bit early, input bit scramble);
    bit got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (bus.R) begin
        got = 1'b1;
      end else begin
        @(posedge clk); #1;
        if (early) bus.MEM_EN = 1'b0;
        if (scramble) begin
          bus.MAR = 16'($urandom);
          bus.MDR = 16'($urandom);
          bus.WE  = 1'($urandom);
        end
      end
    end
    check("r_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic run_txn(input logic we, input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] s, input int hold, input bit early, input bit scramble);
    @(posedge clk); #1;
    s_val      = s;
    bus.MEM_EN = 1'b1;
    bus.WE     = we;
    bus.MAR    = a;
    bus.MDR    = d;
    push_txn(we, a, d);
    wait_r(early, scramble);
    repeat (hold) begin
      @(posedge clk); #1;
      if (scramble) begin
        bus.MAR = 16'($urandom);
        bus.WE  = 1'($urandom);
      end
    end
    @(posedge clk); #1;
    bus.MEM_EN = 1'b0;
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 5))
      0:       return IO;
      1:       return 16'h0200 + 16'($urandom_range(0, 3));
      2:       return 16'h3000 + 16'($urandom_range(0, 3));
      3:       return 16'h2FFF;
      4:       return 16'h4000 + 16'($urandom_range(0, 3));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    sram_mem[16'h3000] = 16'hBEEF;
    ref_mem[16'h3000]  = 16'hBEEF;
    bus.MEM_EN = 1'b0;
    bus.WE     = 1'b0;
    bus.MAR    = 16'h0000;
    bus.MDR    = 16'h0000;
    rst        = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // SRAM read, then write; MDR_In must hold the read value across the write.
    run_txn(1'b0, 16'h3000, 16'h0000, 16'h0000, 0, 1'b0, 1'b0);
    check("tp_read_beef", {16'd0, bus.MDR_In}, 32'hBEEF);
    run_txn(1'b1, 16'h4001, 16'h1234, 16'h0000, 0, 1'b0, 1'b0);
    check("tp_write_keeps_mdr_in", {16'd0, bus.MDR_In}, 32'hBEEF);
    run_txn(1'b0, 16'h4001, 16'h0000, 16'h0000, 0, 1'b0, 1'b0);
    check("tp_readback", {16'd0, bus.MDR_In}, 32'h1234);

    // I/O read of the switches and write of the hex display.
    run_txn(1'b0, 16'hFFFF, 16'h0000, 16'h00A5, 0, 1'b0, 1'b0);
    check("tp_io_read", {16'd0, bus.MDR_In}, 32'h00A5);
    run_txn(1'b1, 16'hFFFF, 16'h0C0D, 16'h0000, 0, 1'b0, 1'b0);
    check("tp_io_write", {16'd0, hex_data}, 32'h0C0D);

    // Request held for 10 cycles after R, then a second transaction.
    run_txn(1'b0, 16'h3000, 16'h0000, 16'h0000, 10, 1'b0, 1'b0);
    run_txn(1'b0, 16'h3000, 16'h0000, 16'h0000, 0, 1'b0, 1'b0);

    // MEM_EN dropped during ACCESS, with the request fields disturbed.
    run_txn(1'b1, 16'h4002, 16'h8421, 16'h0000, 0, 1'b1, 1'b1);

    // Reset in cycle 1 of a write; request stays high and restarts afterwards.
    @(posedge clk); #1;
    bus.MEM_EN = 1'b1;
    bus.WE     = 1'b1;
    bus.MAR    = 16'h4001;
    bus.MDR    = 16'h5555;
    push_txn(1'b1, 16'h4001, 16'h5555);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    push_txn(1'b1, 16'h4001, 16'h5555);
    wait_r(1'b0, 1'b0);
    @(posedge clk); #1;
    bus.MEM_EN = 1'b0;
    check("tp_reset_hex", {16'd0, hex_data}, 32'h0000);
    run_txn(1'b0, 16'h4001, 16'h0000, 16'h0000, 0, 1'b0, 1'b0);
    check("tp_reset_readback", {16'd0, bus.MDR_In}, 32'h5555);

    // Low-address write (refused when write protection is built in).
    run_txn(1'b1, 16'h0200, 16'h7777, 16'h0000, 0, 1'b0, 1'b0);
    run_txn(1'b1, 16'h3000, 16'h2222, 16'h0000, 0, 1'b0, 1'b0);
    run_txn(1'b0, 16'h0200, 16'h0000, 16'h0000, 0, 1'b0, 1'b0);
`ifdef MEM_WRITE_PROTECT_EN
    check("tp_prot_sticky", {31'd0, prot_err}, 32'd1);
    check("tp_prot_no_write", {16'd0, bus.MDR_In}, {16'd0, init_val(16'h0200)});
`else
    check("tp_low_write", {16'd0, bus.MDR_In}, 32'h7777);
`endif

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      run_txn(1'($urandom), pick_addr(), 16'($urandom), 16'($urandom),
              $urandom_range(0, 3), ($urandom_range(0, 3) == 0), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #1 check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the LC-3 datapath's MAR/MDR memory interface.
- Accepts a held read/write request from the control FSM using MEM_EN, WE and MAR, and returns a single-cycle ready pulse R. On reads it also returns MDR_In.
- Drives an external asynchronous SRAM through split data ports, with a programmable number of wait states.
- Decodes one memory-mapped I/O address: reads there return the switches S, and writes there load the hex-display register.

Parameters:
- WAIT_CYCLES, 2, SRAM access cycles per transaction; legal range 1..15.
- IO_ADDR, 16'hFFFF, memory-mapped I/O address (switch read / hex write).

Ports:
- Clk  input  1  system clock; all logic on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- MEM_EN  input  1  request; held high by control until R is seen.
- WE  input  1  1 = write (MDR -> memory), 0 = read.
- MAR  input  16  word address.
- MDR  input  16  write data.
- S  input  16  switch value, returned on reads of IO_ADDR.
- MDR_In  output  16  read data to the datapath MDR mux.
- R  output  1  ready; one-cycle pulse when the transaction completes.
- HEX_DATA  output  16  hex-display register.
- SRAM_ADDR  output  20  SRAM address, {4'b0, MAR}.
- SRAM_D_OUT  output  16  SRAM write data.
- SRAM_D_IN  input  16  SRAM read data.
- SRAM_DQ_OE  output  1  1 = drive SRAM data bus (top-level tristate).
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  output  1 each  SRAM strobes, active low.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - State is IDLE.
  - R=0, MDR_In=0, HEX_DATA=0, SRAM_ADDR=0, SRAM_D_OUT=0, SRAM_DQ_OE=0.
  - All SRAM strobes high (inactive).
- FSM states: IDLE, ACCESS, RESP, RELEASE.
- IDLE:
  - On MEM_EN=1, latch MAR, WE and MDR.
  - If MAR==IO_ADDR, go to RESP; I/O accesses never assert SRAM strobes.
  - Otherwise load wait counter = WAIT_CYCLES-1 and go to ACCESS.
- ACCESS:
  - SRAM_CE_N=0 and SRAM_ADDR = latched address.
  - Read: SRAM_OE_N=0, SRAM_WE_N=1.
  - Write: SRAM_WE_N=0, SRAM_OE_N=1, SRAM_DQ_OE=1, SRAM_D_OUT = latched MDR.
  - Counter decrements each cycle. When it reaches 0, go to RESP; on a read, capture SRAM_D_IN into MDR_In on that same edge.
- RESP:
  - R=1 for exactly one cycle. All strobes inactive, SRAM_DQ_OE=0.
  - I/O read: MDR_In <= S on entry to RESP.
  - I/O write: HEX_DATA <= latched MDR on entry to RESP.
  - Next state is RELEASE.
- RELEASE:
  - Wait for MEM_EN=0, then go to IDLE.
  - A request held high across completion is never re-executed.
- Latency, measured from the first cycle MEM_EN=1 in IDLE:
  - SRAM access: R high WAIT_CYCLES+1 cycles later.
  - I/O access: R high 1 cycle later.
- Back-to-back requests: minimum one cycle of MEM_EN=0 between transactions. A new request is accepted only from IDLE.
- MDR_In holds its value until the next read completes or reset. Writes never change MDR_In.
- HEX_DATA changes only on an I/O write.
- MEM_EN dropping during ACCESS: the access still completes, R still pulses, and RELEASE exits to IDLE on the next cycle.
- MAR, WE or MDR changing after acceptance: ignored, because the latched copies are used.
- Reset mid-transaction: on the next edge, strobes go inactive, R=0 and state is IDLE. No write data is committed to HEX_DATA, and MDR_In is cleared.
- Reset has priority over all other events on the same edge.

Optional Feature:
- Macro: MEM_WRITE_PROTECT_EN.
- When defined:
  - Adds output PROT_ERR (1 bit, sticky, reset 0).
  - Any non-I/O write with latched address < 16'h3000 skips ACCESS and goes directly to RESP. No SRAM strobes are asserted, R still pulses with 1-cycle latency, and PROT_ERR is set to 1.
  - PROT_ERR is cleared only by Reset.
- When undefined: the PROT_ERR port is absent and all addresses are writable.

Test Plan:
- Read, WAIT_CYCLES=2: MAR=16'h3000, WE=0, MEM_EN=1 at cycle 0; SRAM model returns 16'hBEEF. Expect SRAM_OE_N=0 in cycles 1-2, R=1 in cycle 3 only, and MDR_In=16'hBEEF held afterwards.
- Write: MAR=16'h4001, MDR=16'h1234, WE=1. Expect SRAM_WE_N=0, SRAM_DQ_OE=1 and SRAM_D_OUT=16'h1234 for 2 cycles, then one R pulse; MDR_In unchanged.
- I/O: S=16'h00A5 and a read of 16'hFFFF. Expect R at cycle 1, MDR_In=16'h00A5 and no SRAM strobes. Then a write of MDR=16'h0C0D to 16'hFFFF; expect HEX_DATA=16'h0C0D.
- Held request: MEM_EN kept high for 10 cycles after R. Expect exactly one R pulse and one SRAM access. Drop MEM_EN for one cycle, re-raise, and expect a second transaction.
- Reset mid-ACCESS on a write: assert Reset in cycle 1. Expect all strobes high and SRAM_DQ_OE=0 from cycle 2, and no R pulse. With MEM_EN still high, a new transaction starts after Reset drops.
- MEM_WRITE_PROTECT_EN: write to 16'h0200. Expect R at cycle 1, no SRAM_WE_N assertion and PROT_ERR=1, which stays set through a later legal write to 16'h3000.
